// File: rtl/audio_rst_seq.sv
// Power-up reset sequencer: holds all audio resets, then releases them one by one.
// Optional codec clock divider in RUN is built only when AUDIO_RST_SEQ_CLKDIV_EN is defined.
module audio_rst_seq #(
  parameter int NUM_OUT   = 3,
  parameter int HOLD_MIN  = 4,
  parameter int STAGE_DLY = 8,
  parameter int DIV_HALF  = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset_central,
  input  logic               soft_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               seq_done,
  output logic               busy,
  output logic               clk_div
);

  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int MAX_DLY = (HOLD_MIN > STAGE_DLY) ?
                           ((HOLD_MIN > DIV_HALF) ? HOLD_MIN : DIV_HALF) :
                           ((STAGE_DLY > DIV_HALF) ? STAGE_DLY : DIV_HALF);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);

  generate
    if (NUM_OUT < 1 || HOLD_MIN < 1 || STAGE_DLY < 1 || DIV_HALF < 1) begin : g_bad_param
      $error("audio_rst_seq: NUM_OUT, HOLD_MIN, STAGE_DLY and DIV_HALF must all be >= 1");
    end
    if (CNT_W < $clog2(MAX_DLY + 1)) begin : g_bad_cnt_w
      $error("audio_rst_seq: CNT_W too narrow for the longest delay");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_OUT-1:0] r_rst_out;
  logic               r_seq_done;
  logic               r_busy;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [NUM_OUT-1:0] w_idx_mask;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // One-hot mask of the output line selected by the stage index.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_idx_mask
      assign w_idx_mask[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

`ifdef AUDIO_RST_SEQ_CLKDIV_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_HALF - 1);
  logic r_clk_div;
`endif

  // Soft restart mirrors the asynchronous reset but wins only at a clock edge.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_out  <= '1;
      r_seq_done <= 1'b0;
      r_busy     <= 1'b1;
`ifdef AUDIO_RST_SEQ_CLKDIV_EN
      r_clk_div  <= 1'b0;
`endif
    end else if (soft_rst_req) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_out  <= '1;
      r_seq_done <= 1'b0;
      r_busy     <= 1'b1;
`ifdef AUDIO_RST_SEQ_CLKDIV_EN
      r_clk_div  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_rst_out[0] <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= IDX_W'(1);
            if (NUM_OUT == 1) begin
              r_state    <= ST_RUN;
              r_seq_done <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state    <= ST_RELEASE;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_RELEASE: begin
          if (r_cnt == STAGE_LAST) begin
            r_rst_out <= r_rst_out & ~w_idx_mask;
            r_cnt     <= '0;
            r_idx     <= r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) begin
              r_state    <= ST_RUN;
              r_seq_done <= 1'b1;
              r_busy     <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_RUN: begin
`ifdef AUDIO_RST_SEQ_CLKDIV_EN
          if (r_cnt == DIV_LAST) begin
            r_clk_div <= ~r_clk_div;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
`endif
        end

        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  assign rst_out  = r_rst_out;
  assign seq_done = r_seq_done;
  assign busy     = r_busy;
`ifdef AUDIO_RST_SEQ_CLKDIV_EN
  assign clk_div  = r_clk_div;
`else
  assign clk_div  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_rst_seq.sv
// Directed bench for audio_rst_seq: default and minimal instances, hard/soft restarts.
// Divider expectations follow AUDIO_RST_SEQ_CLKDIV_EN as seen by this compile.
`timescale 1ns/1ps
module tb_audio_rst_seq;

  logic       clk = 1'b0;
  logic       rc_def = 1'b1;
  logic       soft_def = 1'b0;
  logic [2:0] rst_def;
  logic       done_def, busy_def, div_def;

  logic       rc_min = 1'b1;
  logic       soft_min = 1'b0;
  logic [0:0] rst_min;
  logic       done_min, busy_min, div_min;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_rst_seq u_dut (
    .clk           (clk),
    .reset_central (rc_def),
    .soft_rst_req  (soft_def),
    .rst_out       (rst_def),
    .seq_done      (done_def),
    .busy          (busy_def),
    .clk_div       (div_def)
  );

  audio_rst_seq #(
    .NUM_OUT  (1),
    .HOLD_MIN (1),
    .DIV_HALF (3)
  ) u_min (
    .clk           (clk),
    .reset_central (rc_min),
    .soft_rst_req  (soft_min),
    .rst_out       (rst_min),
    .seq_done      (done_min),
    .busy          (busy_min),
    .clk_div       (div_min)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".rst_out"}, 32'(rst_def), 32'h7);
    check_val({tag, ".seq_done"}, 32'(done_def), 32'h0);
    check_val({tag, ".busy"}, 32'(busy_def), 32'h1);
    check_val({tag, ".clk_div"}, 32'(div_def), 32'h0);
  endtask

  // Default timeline, relative edge 0 = first edge that counts:
  // rst_out 111 -> 110 @3 -> 100 @11 -> 000 @19, clk_div toggles from edge 20.
  task automatic run_seq(input string tag, input int n);
    logic [2:0] exp_rst;
    logic       exp_div;
    for (int e = 0; e < n; e++) begin
      tick();
      if (e < 3)       exp_rst = 3'b111;
      else if (e < 11) exp_rst = 3'b110;
      else if (e < 19) exp_rst = 3'b100;
      else             exp_rst = 3'b000;
      exp_div = 1'b0;
`ifdef AUDIO_RST_SEQ_CLKDIV_EN
      if (e >= 20) exp_div = ((e - 19) % 2) == 1;
`endif
      check_val($sformatf("%s.rst_out@e%0d", tag, e), 32'(rst_def), 32'(exp_rst));
      check_val($sformatf("%s.seq_done@e%0d", tag, e), 32'(done_def), (e >= 19) ? 32'h1 : 32'h0);
      check_val($sformatf("%s.busy@e%0d", tag, e), 32'(busy_def), (e >= 19) ? 32'h0 : 32'h1);
      check_val($sformatf("%s.clk_div@e%0d", tag, e), 32'(div_def), 32'(exp_div));
    end
    $display("phase %s: %0d edges checked", tag, n);
  endtask

  initial begin
    int hold_cnt;
    logic exp_mdiv;

    tick();
    tick();
    check_reset_state("reset");
    check_val("min.reset.rst_out", 32'(rst_min), 32'h1);
    check_val("min.reset.seq_done", 32'(done_min), 32'h0);
    check_val("min.reset.busy", 32'(busy_min), 32'h1);

    // Release both; the next rising edge is edge 0 for both instances.
    rc_def = 1'b0;
    rc_min = 1'b0;
    for (int e = 0; e < 13; e++) begin
      tick();
      exp_mdiv = 1'b0;
`ifdef AUDIO_RST_SEQ_CLKDIV_EN
      exp_mdiv = ((e / 3) % 2) == 1;
`endif
      check_val($sformatf("min.rst_out@e%0d", e), 32'(rst_min), 32'h0);
      check_val($sformatf("min.seq_done@e%0d", e), 32'(done_min), 32'h1);
      check_val($sformatf("min.busy@e%0d", e), 32'(busy_min), 32'h0);
      check_val($sformatf("min.clk_div@e%0d", e), 32'(div_min), 32'(exp_mdiv));
      // Default instance runs alongside; its early edges are covered again below.
      if (e == 3) check_val("def.rst_out@e3", 32'(rst_def), 32'h6);
      if (e == 11) check_val("def.rst_out@e11", 32'(rst_def), 32'h4);
    end
    $display("phase minimal: 13 edges checked");

    // Fresh default sequence through RUN.
    rc_def = 1'b1;
    #1;
    check_reset_state("async_in_run");
    tick();
    rc_def = 1'b0;
    run_seq("default", 25);

    // Hard reset mid-sequence, between edges 12 and 13.
    rc_def = 1'b1;
    tick();
    rc_def = 1'b0;
    run_seq("pre_mid", 13);
    #2;
    rc_def = 1'b1;
    #1;
    check_reset_state("async_mid");
    tick();
    rc_def = 1'b0;
    run_seq("after_mid", 30);

    // One-cycle soft restart sampled at edge 30 of this run.
    soft_def = 1'b1;
    tick();
    check_reset_state("soft_pulse@e30");
    soft_def = 1'b0;
    run_seq("after_soft", 25);

    // Held soft restart while in RELEASE, 20 samples high.
    soft_def = 1'b1;
    rc_def = 1'b1;
    tick();
    rc_def = 1'b0;
    soft_def = 1'b0;
    run_seq("pre_hold", 8);
    soft_def = 1'b1;
    hold_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      hold_cnt++;
      check_val($sformatf("hold.rst_out@c%0d", c), 32'(rst_def), 32'h7);
      check_val($sformatf("hold.busy@c%0d", c), 32'(busy_def), 32'h1);
    end
    soft_def = 1'b0;
    $display("phase hold: %0d cycles with soft_rst_req high", hold_cnt);
    run_seq("after_hold", 120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
